md_issue_ctrl: RTL and testbench

Issue and hazard controller for the HI/LO multiply/divide unit of the pipelined MIPS core. It accepts multiply, divide and HI/LO-move operations from the E stage and drives the unit's start, control, operand and write-enable inputs. It tracks each operation's fixed latency, stalls the D stage while HI/LO is not yet valid, and cancels an in-flight operation when an exception/interrupt flush hits it in M.

---
 rtl/md_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_md_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue and HI/LO hazard controller for the multiply/divide unit.
// Build option MD_CANCEL_EN: a flush blocks accept and cancels a mult/div in its first RUN cycle.
module md_issue_ctrl #(
    parameter int unsigned MUL_CYC = 5,
    parameter int unsigned DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [4:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    input  logic        d_md_use,
    output logic        stall,
    input  logic        flush,
    output logic        md_start,
    output logic [4:0]  md_ctrl,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_wr_en,
    input  logic        md_busy,
    output logic        md_err
);
    localparam int unsigned MaxCyc = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int unsigned CntW   = ($clog2(MaxCyc + 1) > 4) ? $clog2(MaxCyc + 1) : 4;
    localparam logic [CntW-1:0] MulCnt = CntW'(MUL_CYC);
    localparam logic [CntW-1:0] DivCnt = CntW'(DIV_CYC);
    localparam logic [CntW-1:0] OneCnt = CntW'(1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            killed_q, killed_d;
    logic [4:0]      cur_ctrl_q, cur_ctrl_d;
    logic            md_err_q, md_err_d;

    logic is_md, is_mul, is_mt, in_run, accept, done, kill_now;

    always_comb begin
        is_md    = (op_code >= 5'd1) && (op_code <= 5'd4);
        is_mul   = (op_code == 5'd1) || (op_code == 5'd2);
        is_mt    = (op_code == 5'd7) || (op_code == 5'd8);
        in_run   = (state_q == StRun);
        op_ready = (state_q == StIdle) && !reset;
`ifdef MD_CANCEL_EN
        accept   = op_valid && op_ready && !flush;
`else
        accept   = op_valid && op_ready;
`endif
        done     = in_run && (cnt_q == OneCnt) && !reset;
    end

`ifdef MD_CANCEL_EN
    // The op is in M only during its first RUN cycle; later flushes belong to younger instructions.
    logic first_cycle;
    assign first_cycle = in_run && (cnt_q == ((cur_ctrl_q <= 5'd2) ? MulCnt : DivCnt));
    assign kill_now    = killed_q || (flush && first_cycle);
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign kill_now     = killed_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            killed_q   <= 1'b0;
            cur_ctrl_q <= '0;
            md_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            killed_q   <= killed_d;
            cur_ctrl_q <= cur_ctrl_d;
            md_err_q   <= md_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept && is_md) state_d = StRun;
            StRun:   if (cnt_q == OneCnt) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        cnt_d      = in_run ? (cnt_q - OneCnt) : cnt_q;
        killed_d   = killed_q;
        cur_ctrl_d = cur_ctrl_q;
        md_err_d   = md_err_q | (md_busy != in_run);
        if (accept && is_md) begin
            cnt_d      = is_mul ? MulCnt : DivCnt;
            killed_d   = 1'b0;
            cur_ctrl_d = op_code;
        end
`ifdef MD_CANCEL_EN
        else if (flush && first_cycle) begin
            killed_d = 1'b1;
        end
`else
        killed_d = 1'b0;
`endif
    end

    // Output logic
    always_comb begin
        md_start = 1'b0;
        md_ctrl  = '0;
        md_a     = '0;
        md_b     = '0;
        md_wr_en = 1'b0;
        if (accept && is_md) begin
            md_start = 1'b1;
            md_ctrl  = op_code;
            md_a     = op_a;
            md_b     = op_b;
        end else if (accept && is_mt) begin
            md_ctrl  = op_code;
            md_a     = op_a;
            md_wr_en = 1'b1;
        end else if (done) begin
            md_ctrl  = cur_ctrl_q;
            md_wr_en = !kill_now;
        end
        stall  = d_md_use && !reset && (in_run || (accept && is_md));
        md_err = md_err_q && !reset;
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed vector table, corner sequences and random stimulus
// against a cycle-indexed reference model, with a behavioural HI/LO unit attached.
module tb_md_issue_ctrl;
    localparam int MulCyc = 5;
    localparam int DivCyc = 10;
`ifdef MD_CANCEL_EN
    localparam bit Cancel = 1'b1;
`else
    localparam bit Cancel = 1'b0;
`endif

    logic        clk;
    logic        reset, op_valid, d_md_use, flush, md_busy, busy_ovr;
    logic [4:0]  op_code, md_ctrl;
    logic [31:0] op_a, op_b, md_a, md_b;
    logic        op_ready, stall, md_start, md_wr_en, md_err;

    md_issue_ctrl #(.MUL_CYC(MulCyc), .DIV_CYC(DivCyc)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_a(op_a),
        .op_b(op_b), .op_ready(op_ready), .d_md_use(d_md_use), .stall(stall), .flush(flush),
        .md_start(md_start), .md_ctrl(md_ctrl), .md_a(md_a), .md_b(md_b), .md_wr_en(md_wr_en),
        .md_busy(md_busy), .md_err(md_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural multiply/divide unit
    logic [31:0] hi_q, lo_q, ua, ub;
    logic [4:0]  uctrl;
    int          ucnt;
    logic [63:0] res;
    assign md_busy = busy_ovr ? 1'b0 : (ucnt != 0);

    always_comb begin
        res = '0;
        case (uctrl)
            5'd1: res = {32'd0, ua} * {32'd0, ub};
            5'd2: res = $signed({{32{ua[31]}}, ua}) * $signed({{32{ub[31]}}, ub});
            5'd3: if (ub != 0) res = {ua % ub, ua / ub};
            5'd4: if (ub != 0) res = {32'($signed(ua) % $signed(ub)), 32'($signed(ua) / $signed(ub))};
            default: res = '0;
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            hi_q <= '0; lo_q <= '0; ucnt <= 0; ua <= '0; ub <= '0; uctrl <= '0;
        end else begin
            if (md_start) begin
                ucnt  <= (md_ctrl <= 5'd2) ? MulCyc : DivCyc;
                ua    <= md_a;
                ub    <= md_b;
                uctrl <= md_ctrl;
            end else if (ucnt != 0) begin
                ucnt <= ucnt - 1;
            end
            if (md_wr_en) begin
                if (md_ctrl == 5'd7)      hi_q <= md_a;
                else if (md_ctrl == 5'd8) lo_q <= md_a;
                else begin
                    hi_q <= res[63:32];
                    lo_q <= res[31:0];
                end
            end
        end
    end

    // Reference model: an operation accepted in cycle c occupies cycles c+1 .. c+latency.
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         done_at = -1;
    int         start_cyc = -10;
    logic [4:0] m_ctrl = '0;
    bit         m_killed = 0;
    bit         m_err = 0;
    bit         e_run, e_acc, e_md, s_busy;

    task automatic check(input string name, input logic [73:0] got, input logic [73:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive_check(input logic v, input logic [4:0] code, input logic [31:0] a,
                               input logic [31:0] b, input logic du, input logic fl,
                               input logic rs, input logic bo);
        logic        e_ready, e_stall, e_start, e_wr, e_err;
        logic [4:0]  e_ctrl;
        logic [31:0] e_a, e_b;
        bit          comp, mt;
        op_valid = v; op_code = code; op_a = a; op_b = b;
        d_md_use = du; flush = fl; reset = rs; busy_ovr = bo;
        #3;
        e_run = (done_at >= cyc);
        e_md  = (code >= 5'd1) && (code <= 5'd4);
        mt    = (code == 5'd7) || (code == 5'd8);
        e_acc = 0;
        {e_ready, e_stall, e_start, e_wr, e_err, e_ctrl, e_a, e_b} = '0;
        if (!rs) begin
            e_ready = !e_run;
            e_acc   = v && e_ready && !(Cancel && fl);
            comp    = e_run && (cyc == done_at);
            if (e_acc && e_md) begin
                e_start = 1; e_ctrl = code; e_a = a; e_b = b;
            end else if (e_acc && mt) begin
                e_ctrl = code; e_a = a; e_wr = 1;
            end else if (comp) begin
                e_ctrl = m_ctrl;
                e_wr   = !(m_killed || (Cancel && fl && cyc == start_cyc + 1));
            end
            e_stall = du && (e_run || (e_acc && e_md));
            e_err   = m_err;
        end
        s_busy = md_busy;
        check("outputs", {op_ready, stall, md_start, md_ctrl, md_a, md_b, md_wr_en, md_err},
              {e_ready, e_stall, e_start, e_ctrl, e_a, e_b, e_wr, e_err});
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (reset) begin
            done_at = -1; m_killed = 0; m_err = 0;
        end else begin
            if (s_busy != e_run) m_err = 1;
            if (Cancel && flush && e_run && cyc == start_cyc + 1) m_killed = 1;
            if (e_acc && e_md) begin
                start_cyc = cyc;
                done_at   = cyc + ((op_code <= 5'd2) ? MulCyc : DivCyc);
                m_ctrl    = op_code;
                m_killed  = 0;
            end
        end
        cyc++;
    endtask

    task automatic step(input logic v, input logic [4:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic du, input logic fl, input logic rs,
                        input logic bo);
        drive_check(v, code, a, b, du, fl, rs, bo);
        advance();
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  code;
        logic [31:0] a, b;
        logic        du, fl;
        logic        x_ready, x_start, x_wr, x_stall;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int stall_cnt;
        tbl[0] = '{1, 5'd2, 32'hFFFF_FFFB, 32'd3, 1, 0, 1, 1, 0, 1};
        tbl[1] = '{0, 5'd0, 32'd0, 32'd0, 1, 0, 0, 0, 0, 1};
        tbl[2] = '{0, 5'd0, 32'd0, 32'd0, 1, 0, 0, 0, 0, 1};
        tbl[3] = '{0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 5'd1, 32'd9, 32'd9, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0, 1, 0};
        tbl[6] = '{0, 5'd0, 32'd0, 32'd0, 0, 0, 1, 0, 0, 0};

        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // mult -5 * 3
        for (int i = 0; i < 7; i++) begin
            drive_check(tbl[i].v, tbl[i].code, tbl[i].a, tbl[i].b, tbl[i].du, tbl[i].fl, 0, 0);
            check("tbl_ctl", {op_ready, md_start, md_wr_en, stall},
                  {tbl[i].x_ready, tbl[i].x_start, tbl[i].x_wr, tbl[i].x_stall});
            advance();
        end
        check("mult_hi", hi_q, 32'hFFFF_FFFF);
        check("mult_lo", lo_q, 32'hFFFF_FFF1);

        // divu 100/7 with mflo waiting in D
        step(1, 5'd3, 32'd100, 32'd7, 0, 0, 0, 0);
        stall_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive_check(0, 0, 0, 0, 1, 0, 0, 0);
            if (stall) stall_cnt++;
            advance();
        end
        drive_check(0, 0, 0, 0, 1, 0, 0, 0);
        check("divu_stall_release", {op_ready, stall}, 2'b10);
        advance();
        check("divu_stall_cycles", stall_cnt, 10);
        check("divu_hi", hi_q, 32'd2);
        check("divu_lo", lo_q, 32'd14);

        // mult flushed in its first RUN cycle
        step(1, 5'd2, 32'd7, 32'd9, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        drive_check(0, 0, 0, 0, 0, 0, 0, 0);
        check("kill_wr_en", md_wr_en, !Cancel);
        advance();
        check("kill_hilo", {hi_q, lo_q}, Cancel ? {32'd2, 32'd14} : {32'd0, 32'd63});

        // flush in the second RUN cycle is too late to cancel
        step(1, 5'd2, 32'd6, 32'd7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        drive_check(0, 0, 0, 0, 0, 0, 0, 0);
        check("late_flush_wr_en", md_wr_en, 1'b1);
        advance();
        check("late_flush_hilo", {hi_q, lo_q}, {32'd0, 32'd42});

        // mthi with and without a same-cycle flush
        drive_check(1, 5'd7, 32'h1234, 0, 0, 1, 0, 0);
        check("mthi_flush_wr_en", md_wr_en, !Cancel);
        advance();
        check("mthi_flush_hi", hi_q, Cancel ? 32'd0 : 32'h1234);
        step(1, 5'd7, 32'h1234, 0, 0, 0, 0, 0);
        check("mthi_hi", hi_q, 32'h1234);
        step(1, 5'd8, 32'hBEEF, 0, 0, 0, 0, 0);
        check("mtlo_lo", lo_q, 32'hBEEF);

        // reset during cycle 4 of a div
        step(1, 5'd4, 32'd1000, 32'd3, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
        drive_check(0, 0, 0, 0, 1, 0, 1, 0);
        check("reset_cycle_quiet", {op_ready, stall, md_start, md_wr_en}, 4'b0000);
        advance();
        drive_check(0, 0, 0, 0, 1, 0, 0, 0);
        check("after_reset", {op_ready, stall, md_err}, 3'b100);
        advance();

        // unit reports idle while a multu is running
        step(1, 5'd1, 32'd3, 32'd4, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        drive_check(0, 0, 0, 0, 0, 0, 0, 0);
        check("md_err_set", md_err, 1'b1);
        advance();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        drive_check(0, 0, 0, 0, 0, 0, 0, 0);
        check("md_err_sticky", md_err, 1'b1);
        advance();
        step(0, 0, 0, 0, 0, 0, 1, 0);
        drive_check(0, 0, 0, 0, 0, 0, 0, 0);
        check("md_err_cleared", md_err, 1'b0);
        advance();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom(), $urandom() | 32'd1,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 149) == 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
